// File: rtl/phy_pkg.sv
// Shared types and constants for the PHY transmit path.
package phy_pkg;

   // Serializer control state: preamble, then normal data/idle traffic.
   typedef enum logic [0:0] {
      SER_SYNC,
      SER_RUN
   } ser_state_t;

   // K28.5 comma pattern used as the idle word.
   localparam logic [7:0] IDLE_WORD_DEF = 8'hBC;

endpackage

// File: rtl/piso_shift_reg.sv
// Load/shift register with a registered serial output.
// On load, the first bit of the word goes straight to the output flop and
// the remaining bits are parked in the shift register.
module piso_shift_reg #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk_8f,
   input  logic              reset_L,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   output logic              out
);

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic              out_q, out_d;

   // Next-state: load a fresh word or shift the parked bits toward the line.
   always_comb begin
      sreg_d = sreg_q;
      out_d  = out_q;
      if (load) begin
         if (MSB_FIRST) begin
            out_d  = word[DATA_W-1];
            sreg_d = word << 1;
         end else begin
            out_d  = word[0];
            sreg_d = word >> 1;
         end
      end else begin
         if (MSB_FIRST) begin
            out_d  = sreg_q[DATA_W-1];
            sreg_d = sreg_q << 1;
         end else begin
            out_d  = sreg_q[0];
            sreg_d = sreg_q >> 1;
         end
      end
   end

   // State register; reset aborts the word in flight and forces the line low.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         sreg_q <= '0;
         out_q  <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         out_q  <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial converter: SYNC preamble of idle words, then data words
// accepted on a valid/ready handshake at the load slot, idle words otherwise.
module piso_serializer
   import phy_pkg::*;
#(
   parameter int unsigned       DATA_W     = 8,
   parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(IDLE_WORD_DEF),
   parameter bit                MSB_FIRST  = 1'b1,
   parameter int unsigned       SYNC_WORDS = 4
) (
   input  logic              clk_8f,
   input  logic              reset_L,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic              out,
   output logic              word_start,
   output logic              locked,
   output logic              idle_slot
);

   localparam int unsigned       CNT_W     = $clog2(DATA_W);
   localparam int unsigned       SYNC_W    = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_WORDS - 1);

   if (DATA_W < 2) begin : g_bad_data_w
      $error("piso_serializer: DATA_W must be >= 2");
   end
   if (SYNC_WORDS < 1) begin : g_bad_sync_words
      $error("piso_serializer: SYNC_WORDS must be >= 1");
   end
   if ($bits(IDLE_WORD) != DATA_W) begin : g_bad_idle_w
      $error("piso_serializer: IDLE_WORD width must equal DATA_W");
   end

   ser_state_t        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
   logic              locked_q, locked_d;
   logic              idle_q, idle_d;
   logic              ws_q;
   logic              load_slot;
   logic              transfer;
   logic [DATA_W-1:0] load_word;

   assign load_slot = (bit_cnt_q == LAST_BIT);
   // No path from valid_in into ready_in.
   assign ready_in  = (state_q == SER_RUN) && load_slot && enable;
   assign transfer  = ready_in && valid_in;

   // Next-state: bit counter, FSM and word selection; FSM moves only at load slots.
   always_comb begin
      bit_cnt_d  = load_slot ? '0 : bit_cnt_q + 1'b1;
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      locked_d   = locked_q;
      idle_d     = idle_q;
      load_word  = IDLE_WORD;
      if (load_slot) begin
         unique case (state_q)
            SER_SYNC: begin
               idle_d     = 1'b1;
               locked_d   = 1'b0;
               sync_cnt_d = sync_cnt_q + 1'b1;
               if (sync_cnt_q == LAST_SYNC) begin
                  state_d = SER_RUN;
               end
            end
            SER_RUN: begin
               locked_d = 1'b1;
               if (transfer) begin
                  load_word = data_in;
                  idle_d    = 1'b0;
               end else begin
                  idle_d = 1'b1;
               end
            end
            default: state_d = SER_SYNC;
         endcase
      end
   end

   // Control registers; status flags update at the load edge so they align with out.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= SER_SYNC;
         bit_cnt_q  <= LAST_BIT;
         sync_cnt_q <= '0;
         locked_q   <= 1'b0;
         idle_q     <= 1'b0;
         ws_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sync_cnt_q <= sync_cnt_d;
         locked_q   <= locked_d;
         idle_q     <= idle_d;
         ws_q       <= load_slot;
      end
   end

   piso_shift_reg #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .load    (load_slot),
      .word    (load_word),
      .out     (out)
   );

   assign word_start = ws_q;
   assign locked     = locked_q;
   assign idle_slot  = idle_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: default MSB-first 8-bit serializer plus a 10-bit LSB-first one.
module tb_piso_serializer;

   localparam logic [9:0] IDLE_B = 10'h0BC;

   logic       clk_8f = 1'b0;
   logic       reset_L;
   logic       enable;
   logic [7:0] data_a;
   logic       valid_a;
   logic       ready_a, out_a, ws_a, locked_a, idle_a;
   logic [9:0] data_b;
   logic       valid_b;
   logic       ready_b, out_b, ws_b, locked_b, idle_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_8f = ~clk_8f;

   piso_serializer u_dut_a (
      .clk_8f     (clk_8f),
      .reset_L    (reset_L),
      .enable     (enable),
      .data_in    (data_a),
      .valid_in   (valid_a),
      .ready_in   (ready_a),
      .out        (out_a),
      .word_start (ws_a),
      .locked     (locked_a),
      .idle_slot  (idle_a)
   );

   piso_serializer #(
      .DATA_W     (10),
      .IDLE_WORD  (IDLE_B),
      .MSB_FIRST  (1'b0),
      .SYNC_WORDS (4)
   ) u_dut_b (
      .clk_8f     (clk_8f),
      .reset_L    (reset_L),
      .enable     (enable),
      .data_in    (data_b),
      .valid_in   (valid_b),
      .ready_in   (ready_b),
      .out        (out_b),
      .word_start (ws_b),
      .locked     (locked_b),
      .idle_slot  (idle_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_8f);
      #1;
   endtask

   // Collect n samples of one DUT (sel_b picks DUT B); the first sample is
   // taken after a clock edge when tick_first is set, otherwise right away.
   task automatic grab(input bit sel_b, input bit tick_first, input int n,
                       output logic [63:0] bits, output logic [63:0] ws,
                       output logic [63:0] lk, output logic [63:0] idl,
                       output logic [63:0] rdy);
      bits = '0; ws = '0; lk = '0; idl = '0; rdy = '0;
      for (int i = 0; i < n; i++) begin
         if (tick_first || i > 0) tick();
         bits = {bits[62:0], sel_b ? out_b    : out_a};
         ws   = {ws[62:0],   sel_b ? ws_b     : ws_a};
         lk   = {lk[62:0],   sel_b ? locked_b : locked_a};
         idl  = {idl[62:0],  sel_b ? idle_b   : idle_a};
         rdy  = {rdy[62:0],  sel_b ? ready_b  : ready_a};
      end
   endtask

   // Present a word and hold it until the slot opens; returns just after the accept edge.
   task automatic send(input bit sel_b, input logic [9:0] d);
      int n = 0;
      if (sel_b) begin
         data_b = d; valid_b = 1'b1;
      end else begin
         data_a = d[7:0]; valid_a = 1'b1;
      end
      while (!(sel_b ? ready_b : ready_a) && n < 64) begin
         tick();
         n++;
      end
      check(sel_b ? "send_b_ready" : "send_a_ready", 64'(sel_b ? ready_b : ready_a), 64'd1);
      tick();
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   initial begin
      logic [63:0] bits, ws, lk, idl, rdy;
      logic [63:0] bb, bws, blk, bidl, brdy;
      logic [63:0] exp_b;
      logic [9:0]  idle_b_v;
      logic        r0, r1;

      reset_L = 1'b0;
      enable  = 1'b1;
      data_a  = '0;
      valid_a = 1'b0;
      data_b  = '0;
      valid_b = 1'b0;
      #2;
      check("rst_out",    64'(out_a),    64'd0);
      check("rst_ready",  64'(ready_a),  64'd0);
      check("rst_ws",     64'(ws_a),     64'd0);
      check("rst_locked", 64'(locked_a), 64'd0);
      check("rst_idle",   64'(idle_a),   64'd0);
      repeat (3) tick();
      reset_L = 1'b1;

      // 1: preamble on both DUTs over 40 edges.
      bits = '0; ws = '0; lk = '0; idl = '0; rdy = '0;
      bb = '0; blk = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         bits = {bits[62:0], out_a};
         ws   = {ws[62:0], ws_a};
         lk   = {lk[62:0], locked_a};
         rdy  = {rdy[62:0], ready_a};
         bb   = {bb[62:0], out_b};
         blk  = {blk[62:0], locked_b};
      end
      check("pre_bits",   bits, 64'hBC_BC_BC_BC_BC);
      check("pre_ws",     ws,   64'h80_80_80_80_80);
      check("pre_locked", lk,   64'h00_00_00_00_FF);
      check("pre_ready",  rdy,  64'h00_00_00_01_01);
      idle_b_v = IDLE_B;
      exp_b = '0;
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 10; i++) exp_b = {exp_b[62:0], idle_b_v[i]};
      check("pre_b_bits",   bb,  exp_b);
      check("pre_b_locked", blk, 64'd0);

      // 2: single data word.
      send(1'b0, 10'h0A5);
      grab(1'b0, 1'b0, 8, bits, ws, lk, idl, rdy);
      check("a5_bits",   bits, 64'hA5);
      check("a5_ws",     ws,   64'h80);
      check("a5_idle",   idl,  64'h00);
      check("a5_locked", lk,   64'hFF);

      // 3: back-to-back words, no gap.
      data_a = 8'h01; valid_a = 1'b1;
      r0 = ready_a;
      r1 = 1'b0;
      bits = '0; idl = '0;
      for (int i = 0; i < 16; i++) begin
         tick();
         bits = {bits[62:0], out_a};
         idl  = {idl[62:0], idle_a};
         if (i == 0) data_a = 8'h80;
         if (i == 7) r1 = ready_a;
         if (i == 8) valid_a = 1'b0;
      end
      check("b2b_ready0", 64'(r0), 64'd1);
      check("b2b_ready1", 64'(r1), 64'd1);
      check("b2b_bits",   bits,    64'h0180);
      check("b2b_idle",   idl,     64'h0000);

      // 5: enable drops mid-word; word completes, then idle with no acceptance.
      send(1'b0, 10'h0FF);
      bits = 64'(out_a);
      for (int i = 1; i < 8; i++) begin
         tick();
         if (i == 3) begin
            enable = 1'b0; data_a = 8'h12; valid_a = 1'b1;
         end
         bits = {bits[62:0], out_a};
      end
      check("en_word_done", bits, 64'hFF);
      check("en_ready_off", 64'(ready_a), 64'd0);
      grab(1'b0, 1'b1, 8, bits, ws, lk, idl, rdy);
      check("en_idle_bits", bits, 64'hBC);
      check("en_idle_flag", idl,  64'hFF);
      check("en_idle_ws",   ws,   64'h80);
      check("en_idle_rdy",  rdy,  64'h00);
      valid_a = 1'b0;
      enable  = 1'b1;

      // 4: LSB-first 10-bit word 10'h3.
      send(1'b1, 10'h003);
      grab(1'b1, 1'b0, 10, bb, bws, blk, bidl, brdy);
      check("lsb_bits",   bb,   64'h300);
      check("lsb_ws",     bws,  64'h200);
      check("lsb_idle",   bidl, 64'h000);
      check("lsb_locked", blk,  64'h3FF);

      // 6: reset mid-word, then a full preamble before the held word is taken.
      send(1'b0, 10'h0F0);
      repeat (3) tick();
      check("mid_bit3", 64'(out_a), 64'd1);
      #2;
      reset_L = 1'b0;
      #1;
      check("abort_out",    64'(out_a),    64'd0);
      check("abort_locked", 64'(locked_a), 64'd0);
      check("abort_ws",     64'(ws_a),     64'd0);
      check("abort_ready",  64'(ready_a),  64'd0);
      data_a = 8'h77; valid_a = 1'b1;
      repeat (2) tick();
      reset_L = 1'b1;
      grab(1'b0, 1'b1, 40, bits, ws, lk, idl, rdy);
      check("rst2_bits",   bits, 64'hBC_BC_BC_BC_77);
      check("rst2_locked", lk,   64'h00_00_00_00_FF);
      check("rst2_ready",  rdy,  64'h00_00_00_01_01);
      check("rst2_idle",   idl & 64'hFF, 64'h00);
      valid_a = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
